// File: rtl/cache_mem_arbiter.sv
// Memory-side arbiter for the cache_control_if protocol: shares one RAM port
// between the icache and dcache channels of every CPU with round-robin CPU selection.
module cache_mem_arbiter #(
    parameter int          CPUS    = 2,
    parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS*32-1:0]   iaddr,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*32-1:0]   daddr,
    input  logic [CPUS*32-1:0]   dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS*32-1:0]   iload,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*32-1:0]   dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate
);

    localparam int          CW   = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int unsigned NCPU = CPUS;

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_SERVE = 1'b1;

    localparam logic [1:0] KIND_IREN = 2'd0;
    localparam logic [1:0] KIND_DREN = 2'd1;
    localparam logic [1:0] KIND_DWEN = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    logic          state_q;
    logic [CW-1:0] gnt_cpu_q;
    logic [1:0]    gnt_kind_q;
    logic [CW-1:0] rr_q;

    logic [CPUS-1:0] any_req;
    logic            req_found;
    logic [CW-1:0]   pick_cpu;
    logic [1:0]      pick_kind;

    logic            gnt_req;
    logic [31:0]     gnt_addr;
    logic [31:0]     gnt_store;
    logic            serving;
    logic            done;
    logic            abort;
    logic [31:0]     load_val;
    logic [CW-1:0]   rr_next;

    always_comb begin
        for (int unsigned c = 0; c < NCPU; c++) begin
            any_req[c] = iREN[c] | dREN[c] | dWEN[c];
        end
    end

    // Round-robin scan: step k visits cpu (rr + k) mod CPUS; the first requester wins.
    always_comb begin
        req_found = 1'b0;
        pick_cpu  = '0;
        pick_kind = KIND_IREN;
        for (int unsigned k = 0; k < NCPU; k++) begin
            for (int unsigned c = 0; c < NCPU; c++) begin
                if (!req_found && any_req[c] && (((32'(rr_q) + k) % NCPU) == c)) begin
                    req_found = 1'b1;
                    pick_cpu  = CW'(c);
                    if (dWEN[c]) begin
                        pick_kind = KIND_DWEN;
                    end else if (dREN[c]) begin
                        pick_kind = KIND_DREN;
                    end else begin
                        pick_kind = KIND_IREN;
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_req   = 1'b0;
        gnt_addr  = '0;
        gnt_store = '0;
        for (int unsigned c = 0; c < NCPU; c++) begin
            if (CW'(c) == gnt_cpu_q) begin
                gnt_store = dstore[c*32 +: 32];
                case (gnt_kind_q)
                    KIND_DWEN: begin
                        gnt_req  = dWEN[c];
                        gnt_addr = daddr[c*32 +: 32];
                    end
                    KIND_DREN: begin
                        gnt_req  = dREN[c];
                        gnt_addr = daddr[c*32 +: 32];
                    end
                    default: begin
                        gnt_req  = iREN[c];
                        gnt_addr = iaddr[c*32 +: 32];
                    end
                endcase
            end
        end
    end

    // A dropped request line wins over a same-cycle completion: the cache no longer wants it.
    assign serving  = (state_q == STATE_SERVE) && gnt_req;
    assign done     = serving && ((ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR));
    assign abort    = (state_q == STATE_SERVE) && !gnt_req;
    assign load_val = (ramstate == RAM_ERROR) ? ERRWORD : ramload;
    assign rr_next  = (gnt_cpu_q == CW'(CPUS - 1)) ? '0 : gnt_cpu_q + 1'b1;

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (serving) begin
            ramaddr = gnt_addr;
            if (gnt_kind_q == KIND_DWEN) begin
                ramWEN   = 1'b1;
                ramstore = gnt_store;
            end else begin
                ramREN = 1'b1;
            end
        end
        if (done) begin
            for (int unsigned c = 0; c < NCPU; c++) begin
                if (CW'(c) == gnt_cpu_q) begin
                    if (gnt_kind_q == KIND_IREN) begin
                        iwait[c]          = 1'b0;
                        iload[c*32 +: 32] = load_val;
                    end else begin
                        dwait[c]          = 1'b0;
                        dload[c*32 +: 32] = load_val;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= STATE_IDLE;
            gnt_cpu_q  <= '0;
            gnt_kind_q <= KIND_IREN;
            rr_q       <= '0;
        end else begin
            case (state_q)
                STATE_IDLE: begin
                    if (req_found) begin
                        state_q    <= STATE_SERVE;
                        gnt_cpu_q  <= pick_cpu;
                        gnt_kind_q <= pick_kind;
                    end
                end
                default: begin
                    if (abort) begin
                        state_q <= STATE_IDLE;
                    end else if (done) begin
                        state_q <= STATE_IDLE;
                        rr_q    <= rr_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus a random
// protocol-following phase, all compared against a transaction-level reference model.
module tb_cache_mem_arbiter;

    localparam int          CPUS    = 2;
    localparam logic [31:0] ERRWORD = 32'hBAD1BAD1;

    logic                CLK;
    logic                nRST;
    logic [CPUS-1:0]     iREN, dREN, dWEN;
    logic [CPUS*32-1:0]  iaddr, daddr, dstore;
    logic [CPUS-1:0]     iwait, dwait;
    logic [CPUS*32-1:0]  iload, dload;
    logic                ramREN, ramWEN;
    logic [31:0]         ramaddr, ramstore, ramload;
    logic [1:0]          ramstate;

    cache_mem_arbiter #(.CPUS(CPUS), .ERRWORD(ERRWORD)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .iload(iload), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    // Reference model: one outstanding transaction (cpu, kind 0=ifetch 1=dread 2=dwrite) plus rr pointer.
    bit m_busy;
    int m_cpu, m_kind, m_rr;
    bit n_busy;
    int n_cpu, n_kind, n_rr;
    logic [CPUS-1:0] x_iwait, x_dwait;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit live_req(input int c, input int k);
        if (k == 2) return dWEN[c];
        if (k == 1) return dREN[c];
        return iREN[c];
    endfunction

    task automatic model_check();
        logic [CPUS-1:0]    e_iwait, e_dwait;
        logic [CPUS*32-1:0] e_iload, e_dload;
        logic               e_ren, e_wen;
        logic [31:0]        e_addr, e_store, ld;
        e_iwait = '1; e_dwait = '1; e_iload = '0; e_dload = '0;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
        n_busy = m_busy; n_cpu = m_cpu; n_kind = m_kind; n_rr = m_rr;
        if (!nRST) begin
            n_busy = 0; n_rr = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < CPUS; k++) begin
                int c;
                c = (m_rr + k) % CPUS;
                if (!n_busy && (iREN[c] || dREN[c] || dWEN[c])) begin
                    n_busy = 1; n_cpu = c;
                    n_kind = dWEN[c] ? 2 : (dREN[c] ? 1 : 0);
                end
            end
        end else if (!live_req(m_cpu, m_kind)) begin
            n_busy = 0;
        end else begin
            e_addr  = (m_kind == 0) ? iaddr[m_cpu*32 +: 32] : daddr[m_cpu*32 +: 32];
            e_ren   = (m_kind != 2);
            e_wen   = (m_kind == 2);
            e_store = e_wen ? dstore[m_cpu*32 +: 32] : 32'h0;
            if (ramstate == 2'd2 || ramstate == 2'd3) begin
                ld = (ramstate == 2'd3) ? ERRWORD : ramload;
                if (m_kind == 0) begin
                    e_iwait[m_cpu] = 1'b0; e_iload[m_cpu*32 +: 32] = ld;
                end else begin
                    e_dwait[m_cpu] = 1'b0; e_dload[m_cpu*32 +: 32] = ld;
                end
                n_busy = 0;
                n_rr   = (m_cpu + 1) % CPUS;
            end
        end
        x_iwait = e_iwait; x_dwait = e_dwait;
        chk("iwait", 64'(iwait), 64'(e_iwait));
        chk("dwait", 64'(dwait), 64'(e_dwait));
        chk("iload", iload, e_iload);
        chk("dload", dload, e_dload);
        chk("ramREN", 64'(ramREN), 64'(e_ren));
        chk("ramWEN", 64'(ramWEN), 64'(e_wen));
        chk("ramaddr", 64'(ramaddr), 64'(e_addr));
        chk("ramstore", 64'(ramstore), 64'(e_store));
    endtask

    task automatic advance();
        @(posedge CLK);
        if (!nRST) begin
            m_busy = 0; m_rr = 0;
        end else begin
            m_busy = n_busy; m_cpu = n_cpu; m_kind = n_kind; m_rr = n_rr;
        end
        #1;
    endtask

    task automatic cyc();
        @(negedge CLK);
        model_check();
        advance();
    endtask

    int cnt0, cnt1;
    bit i_act [CPUS];
    bit d_act [CPUS];

    initial begin
        nRST = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = 2'd0;
        m_busy = 0; m_cpu = 0; m_kind = 0; m_rr = 0;
        #3;
        model_check();
        chk("rst_iwait", 64'(iwait), 64'h3);
        chk("rst_ramREN", 64'(ramREN), 64'h0);
        advance();
        nRST = 1'b1;
        cyc();

        // ifetch with two BUSY cycles before ACCESS
        iREN = 2'b01; iaddr[31:0] = 32'h40;
        cyc();
        ramstate = 2'd1;
        @(negedge CLK); model_check();
        chk("t1_ren", 64'(ramREN), 64'h1);
        chk("t1_addr", 64'(ramaddr), 64'h40);
        advance();
        cyc();
        ramstate = 2'd2; ramload = 32'h12345678;
        @(negedge CLK); model_check();
        chk("t1_iwait", 64'(iwait), 64'h2);
        chk("t1_iload", 64'(iload[31:0]), 64'h12345678);
        advance();
        iREN = '0; ramstate = 2'd0;
        @(negedge CLK); model_check();
        chk("t1_idle_ren", 64'(ramREN), 64'h0);
        advance();

        // write beats ifetch on the same CPU; ifetch follows after the IDLE cycle
        dWEN = 2'b01; iREN = 2'b01; daddr[31:0] = 32'h80; dstore[31:0] = 32'hDEADBEEF;
        iaddr[31:0] = 32'h44;
        cyc();
        ramstate = 2'd2;
        @(negedge CLK); model_check();
        chk("t2_wen", 64'(ramWEN), 64'h1);
        chk("t2_ren", 64'(ramREN), 64'h0);
        chk("t2_store", 64'(ramstore), 64'hDEADBEEF);
        chk("t2_dwait", 64'(dwait), 64'h2);
        advance();
        dWEN = '0;
        @(negedge CLK); model_check();
        chk("t2_gap", 64'({ramREN, ramWEN}), 64'h0);
        advance();
        @(negedge CLK); model_check();
        chk("t2_ifetch", 64'(iwait), 64'h2);
        chk("t2_iaddr", 64'(ramaddr), 64'h44);
        advance();
        iREN = '0;
        cyc();

        // two CPUs streaming ifetches alternate
        iREN = 2'b11; iaddr = {32'h2000, 32'h1000};
        cnt0 = 0; cnt1 = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge CLK); model_check();
            if (!iwait[0]) cnt0++;
            if (!iwait[1]) cnt1++;
            advance();
        end
        chk("t3_cpu0_cnt", 64'(cnt0), 64'd2);
        chk("t3_cpu1_cnt", 64'(cnt1), 64'd2);
        iREN = '0;
        cyc();

        // ERROR response on CPU1 dread
        dREN = 2'b10; daddr[63:32] = 32'h300;
        ramstate = 2'd0;
        cyc();
        ramstate = 2'd3;
        @(negedge CLK); model_check();
        chk("t4_dwait", 64'(dwait), 64'h1);
        chk("t4_dload", 64'(dload[63:32]), 64'(ERRWORD));
        advance();
        dREN = '0; ramstate = 2'd0;
        cyc();

        // abort: CPU0 dread dropped while BUSY, rr stays at 0
        dREN = 2'b01; daddr[31:0] = 32'h100;
        cyc();
        ramstate = 2'd1;
        cyc();
        dREN = '0;
        cyc();
        iREN = 2'b11;
        @(negedge CLK); model_check();
        chk("t5_ren", 64'(ramREN), 64'h0);
        chk("t5_dwait", 64'(dwait), 64'h3);
        advance();
        ramstate = 2'd2;
        @(negedge CLK); model_check();
        chk("t5_rr_cpu0", 64'(ramaddr), 64'h1000);
        advance();
        iREN = '0; ramstate = 2'd0;
        cyc();

        // reset mid-SERVE, then re-arbitration from CPU0 (rr was 1)
        iREN = 2'b11;
        cyc();
        ramstate = 2'd1;
        @(negedge CLK); model_check();
        chk("t6_pre_addr", 64'(ramaddr), 64'h2000);
        #2 nRST = 1'b0;
        #1;
        chk("t6_rst_ren", 64'({ramREN, ramWEN}), 64'h0);
        chk("t6_rst_wait", 64'({iwait, dwait}), 64'hF);
        advance();
        nRST = 1'b1;
        cyc();
        ramstate = 2'd2;
        @(negedge CLK); model_check();
        chk("t6_cpu0", 64'(ramaddr), 64'h1000);
        chk("t6_iwait", 64'(iwait), 64'h2);
        advance();
        iREN = '0;
        cyc();

        // random phase: caches hold requests until their wait drops, occasional aborts
        for (int c = 0; c < CPUS; c++) begin i_act[c] = 0; d_act[c] = 0; end
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < CPUS; c++) begin
                if (!i_act[c] && $urandom_range(2, 0) == 0) begin
                    i_act[c] = 1; iREN[c] = 1'b1; iaddr[c*32 +: 32] = $urandom;
                end else if (i_act[c] && $urandom_range(39, 0) == 0) begin
                    i_act[c] = 0; iREN[c] = 1'b0;
                end
                if (!d_act[c] && $urandom_range(2, 0) == 0) begin
                    d_act[c] = 1;
                    if ($urandom_range(1, 0) == 1) dWEN[c] = 1'b1; else dREN[c] = 1'b1;
                    daddr[c*32 +: 32] = $urandom; dstore[c*32 +: 32] = $urandom;
                end else if (d_act[c] && $urandom_range(39, 0) == 0) begin
                    d_act[c] = 0; dREN[c] = 1'b0; dWEN[c] = 1'b0;
                end
            end
            ramstate = 2'($urandom_range(3, 0));
            ramload  = $urandom;
            cyc();
            for (int c = 0; c < CPUS; c++) begin
                if (!x_iwait[c]) begin i_act[c] = 0; iREN[c] = 1'b0; end
                if (!x_dwait[c]) begin d_act[c] = 0; dREN[c] = 1'b0; dWEN[c] = 1'b0; end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
